// File: rtl/dense_argmax_feed.sv
// Dense output layer: per neuron, accumulates IN_NUM signed activation*weight products,
// scales by an arithmetic right shift, saturates, and writes the score for the argmax stage.
module dense_argmax_feed #(
  parameter int unsigned SIZE_1           = 12,
  parameter int unsigned SIZE_address_pix = 13,
  parameter int unsigned SIZE_address_wei = 13,
  parameter int unsigned IN_NUM           = 16,
  parameter int unsigned OUT_NUM          = 11,
  parameter int unsigned SHIFT            = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  output logic                        STOP,
  input  logic [SIZE_address_pix-1:0] memstartp,
  input  logic [SIZE_address_wei-1:0] memstartw,
  input  logic [SIZE_address_pix-1:0] memstartzap,
  input  logic [SIZE_1-1:0]           qp,
  input  logic [SIZE_1-1:0]           qw,
  output logic                        re_p,
  output logic                        re_w,
  output logic [SIZE_address_pix-1:0] read_addressp,
  output logic [SIZE_address_wei-1:0] read_addressw,
  output logic                        we,
  output logic [SIZE_address_pix-1:0] write_addressp,
  output logic [SIZE_1-1:0]           dp
);

  localparam int unsigned AccW = 2 * SIZE_1 + $clog2(IN_NUM);
  localparam int unsigned IW   = (IN_NUM > 1) ? $clog2(IN_NUM) : 1;
  localparam int unsigned OW   = (OUT_NUM > 1) ? $clog2(OUT_NUM) : 1;
  localparam logic [IW-1:0] ILast = IW'(IN_NUM - 1);
  localparam logic [OW-1:0] OLast = OW'(OUT_NUM - 1);
  localparam logic signed [AccW-1:0] SatMax = AccW'((1 << (SIZE_1 - 1)) - 1);
  localparam logic signed [AccW-1:0] SatMin = ~SatMax;

  typedef enum logic [2:0] {StIdle, StFetch, StLast, StWrite, StDone} state_e;

  state_e                   r_state, w_state_next;
  logic [IW-1:0]            r_i, w_i_next;
  logic [OW-1:0]            r_o, w_o_next;
  logic signed [AccW-1:0]   r_acc, w_acc_next;

  logic signed [2*SIZE_1-1:0] w_qp_ext, w_qw_ext, w_prod;
  logic signed [AccW-1:0]     w_shifted;
  logic [SIZE_1-1:0]          w_dp_sat;
  logic [SIZE_address_pix-1:0] w_addr_p, w_addr_z;
  logic [SIZE_address_wei-1:0] w_addr_w;

  // Operands are sign-extended so the truncated product keeps its full signed value.
  assign w_qp_ext = {{SIZE_1{qp[SIZE_1-1]}}, qp};
  assign w_qw_ext = {{SIZE_1{qw[SIZE_1-1]}}, qw};
  assign w_prod   = w_qp_ext * w_qw_ext;

  assign w_shifted = r_acc >>> SHIFT;
  always_comb begin
    if (w_shifted > SatMax) begin
      w_dp_sat = {1'b0, {(SIZE_1 - 1){1'b1}}};
    end else if (w_shifted < SatMin) begin
      w_dp_sat = {1'b1, {(SIZE_1 - 1){1'b0}}};
    end else begin
      w_dp_sat = w_shifted[SIZE_1-1:0];
    end
  end

  assign w_addr_p = memstartp + SIZE_address_pix'(r_i);
  assign w_addr_w = SIZE_address_wei'(32'(memstartw) + 32'(r_o) * IN_NUM + 32'(r_i));
  assign w_addr_z = memstartzap + SIZE_address_pix'(r_o);

  // enable low behaves exactly like reset: abandons any partial neuron.
  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      r_state <= StIdle;
      r_i     <= '0;
      r_o     <= '0;
      r_acc   <= '0;
    end else begin
      r_state <= w_state_next;
      r_i     <= w_i_next;
      r_o     <= w_o_next;
      r_acc   <= w_acc_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_i_next       = r_i;
    w_o_next       = r_o;
    w_acc_next     = r_acc;
    STOP           = 1'b0;
    re_p           = 1'b0;
    re_w           = 1'b0;
    we             = 1'b0;
    read_addressp  = '0;
    read_addressw  = '0;
    write_addressp = '0;
    dp             = '0;
    case (r_state)
      StIdle: begin
        w_state_next = StFetch;
        w_i_next     = '0;
        w_o_next     = '0;
        w_acc_next   = '0;
      end
      StFetch: begin
        re_p          = 1'b1;
        re_w          = 1'b1;
        read_addressp = w_addr_p;
        read_addressw = w_addr_w;
        // Read data lags the address by one cycle, so index 0 has nothing to add yet.
        if (r_i != '0) w_acc_next = r_acc + AccW'(w_prod);
        if (r_i == ILast) begin
          w_state_next = StLast;
        end else begin
          w_i_next = r_i + 1'b1;
        end
      end
      StLast: begin
        w_acc_next   = r_acc + AccW'(w_prod);
        w_state_next = StWrite;
      end
      StWrite: begin
        we             = 1'b1;
        write_addressp = w_addr_z;
        dp             = w_dp_sat;
        w_acc_next     = '0;
        w_i_next       = '0;
        if (r_o == OLast) begin
          w_state_next = StDone;
        end else begin
          w_o_next     = r_o + 1'b1;
          w_state_next = StFetch;
        end
      end
      StDone: begin
        STOP = 1'b1;
      end
      default: w_state_next = StIdle;
    endcase
  end

endmodule

// File: tb/tb_dense_argmax_feed.sv
// Scoreboard bench: two DUTs (SHIFT=0 and SHIFT=1) share one memory model; expected scores
// are computed from the memory contents and popped as each write appears.
module tb_dense_argmax_feed;

  localparam int IN  = 16;
  localparam int OUT = 11;
  localparam int MP  = 100;
  localparam int MW  = 1000;
  localparam int ZAP = 3000;

  typedef struct {
    logic [12:0] addr;
    logic [11:0] d0;
    logic [11:0] d1;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, enable;
  logic [11:0] qp, qw;
  logic        STOP, re_p, re_w, we;
  logic [12:0] read_addressp, read_addressw, write_addressp;
  logic [11:0] dp;
  logic        d1_stop, d1_re_p, d1_re_w, d1_we;
  logic [12:0] d1_rap, d1_raw, d1_wap;
  logic [11:0] d1_dp;

  logic signed [11:0] pmem [8192];
  logic signed [11:0] wmem [8192];
  exp_t sb[$];
  int   scores [OUT];
  int   n_checks = 0;
  int   n_errors = 0;
  int   lat, nw, best;

  always #5 clk = ~clk;

  dense_argmax_feed #(.SHIFT(0), .IN_NUM(IN), .OUT_NUM(OUT)) u_dut0 (
    .clk(clk), .rst(rst), .enable(enable), .STOP(STOP),
    .memstartp(13'(MP)), .memstartw(13'(MW)), .memstartzap(13'(ZAP)),
    .qp(qp), .qw(qw), .re_p(re_p), .re_w(re_w),
    .read_addressp(read_addressp), .read_addressw(read_addressw),
    .we(we), .write_addressp(write_addressp), .dp(dp)
  );

  dense_argmax_feed #(.SHIFT(1), .IN_NUM(IN), .OUT_NUM(OUT)) u_dut1 (
    .clk(clk), .rst(rst), .enable(enable), .STOP(d1_stop),
    .memstartp(13'(MP)), .memstartw(13'(MW)), .memstartzap(13'(ZAP)),
    .qp(qp), .qw(qw), .re_p(d1_re_p), .re_w(d1_re_w),
    .read_addressp(d1_rap), .read_addressw(d1_raw),
    .we(d1_we), .write_addressp(d1_wap), .dp(d1_dp)
  );

  // Synchronous read memories, one cycle of latency.
  always @(posedge clk) begin
    if (re_p) qp <= pmem[read_addressp];
    if (re_w) qw <= wmem[read_addressw];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] model_dp(input int o, input int sh);
    longint acc = 0;
    logic [12:0] pa, wa;
    for (int i = 0; i < IN; i++) begin
      pa = 13'(MP + i);
      wa = 13'(MW + o * IN + i);
      acc += longint'(pmem[pa]) * longint'(wmem[wa]);
    end
    acc = acc >>> sh;
    if (acc > 2047) acc = 2047;
    if (acc < -2048) acc = -2048;
    return 12'(acc);
  endfunction

  task automatic push_expected();
    for (int o = 0; o < OUT; o++)
      sb.push_back('{addr: 13'(ZAP + o), d0: model_dp(o, 0), d1: model_dp(o, 1)});
  endtask

  task automatic fill(input int pv, input int wv);
    for (int i = 0; i < IN; i++) pmem[MP + i] = 12'(pv);
    for (int k = 0; k < IN * OUT; k++) wmem[MW + k] = 12'(wv);
  endtask

  // Called at a negedge; raises enable and watches writes until STOP, abort or timeout.
  task automatic run_layer(input int abort_at, output int lat_o, output int nw_o);
    exp_t e;
    int   idx;
    lat_o  = -1;
    nw_o   = 0;
    enable = 1'b1;
    for (int c = 1; c <= 400; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (we) begin
        nw_o++;
        if (sb.size() == 0) begin
          check_eq("extra_write", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check_eq("waddr", 32'(write_addressp), 32'(e.addr));
          check_eq("dp_shift0", 32'(dp), 32'(e.d0));
          check_eq("we_shift1", 32'(d1_we), 32'd1);
          check_eq("dp_shift1", 32'(d1_dp), 32'(e.d1));
          idx = int'(write_addressp) - ZAP;
          if (idx >= 0 && idx < OUT) scores[idx] = int'($signed(dp));
        end
      end
      if (STOP) begin
        lat_o = c;
        break;
      end
      if (c == abort_at) begin
        enable = 1'b0;
        break;
      end
    end
  endtask

  task automatic full_layer(input string tag);
    push_expected();
    run_layer(0, lat, nw);
    check_eq({tag, "_latency"}, 32'(lat), 32'd199);
    check_eq({tag, "_writes"}, 32'(nw), 32'(OUT));
    check_eq({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
  endtask

  task automatic drop_enable();
    enable = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_eq("idle_stop", 32'(STOP), 32'd0);
  endtask

  initial begin
    for (int a = 0; a < 8192; a++) begin
      pmem[a] = '0;
      wmem[a] = '0;
    end
    rst    = 1'b1;
    enable = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_stop", 32'(STOP), 32'd0);
    check_eq("rst_re", 32'({re_p, re_w, we}), 32'd0);
    check_eq("rst_addr", 32'({read_addressp, read_addressw, write_addressp}), 32'd0);
    check_eq("rst_dp", 32'(dp), 32'd0);
    rst    = 1'b0;
    enable = 1'b0;
    @(posedge clk);
    @(negedge clk);

    fill(1, 1);
    full_layer("ones");
    @(posedge clk);
    @(negedge clk);
    check_eq("done_hold_stop", 32'(STOP), 32'd1);
    check_eq("done_hold_en", 32'({re_p, re_w, we}), 32'd0);
    drop_enable();

    fill(2, 0);
    for (int o = 0; o < OUT; o++)
      for (int i = 0; i < IN; i++) wmem[MW + o * IN + i] = 12'(o - 5);
    full_layer("signed");
    best = 0;
    for (int o = 1; o < OUT; o++) if (scores[o] > scores[best]) best = o;
    check_eq("argmax", 32'(best), 32'd10);
    drop_enable();

    fill(2047, 2047);
    full_layer("sat_pos");
    drop_enable();
    fill(2047, -2048);
    full_layer("sat_neg");
    drop_enable();

    fill(0, 1);
    pmem[MP] = -12'sd3;
    full_layer("round");
    drop_enable();

    // Abort inside neuron 4's fetch phase, then restart.
    fill(2, 0);
    for (int o = 0; o < OUT; o++)
      for (int i = 0; i < IN; i++) wmem[MW + o * IN + i] = 12'(o - 5 + i);
    push_expected();
    run_layer(78, lat, nw);
    check_eq("abort_writes", 32'(nw), 32'd4);
    @(posedge clk);
    @(negedge clk);
    check_eq("abort_idle", 32'({STOP, re_p, re_w, we}), 32'd0);
    sb.delete();
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      check_eq("abort_no_write", 32'(we), 32'd0);
    end
    full_layer("restart");

    // Reset while in DONE with enable held high.
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_eq("rst_done_stop", 32'(STOP), 32'd0);
    check_eq("rst_done_we", 32'(we), 32'd0);
    rst = 1'b0;
    full_layer("rerun");
    drop_enable();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/dense_argmax_feed.md
Name: dense_argmax_feed

Overview:
- Final fully connected (dense) layer of the classifier datapath.
- For each of OUT_NUM neurons, reads IN_NUM signed activations and IN_NUM signed weights from memory and accumulates their products.
- Scales and saturates each sum, then writes the OUT_NUM scores to consecutive addresses starting at memstartzap.
- Sits directly upstream of the argmax result stage, which reads those scores back; handshake is the usual enable/STOP pair.

Parameters:
- SIZE_1, 12: signed activation/weight/output word width.
- SIZE_address_pix, 13: activation/output memory address width.
- SIZE_address_wei, 13: weight memory address width.
- IN_NUM, 16: inputs per neuron (>=1).
- OUT_NUM, 11: neurons (>=1).
- SHIFT, 8: arithmetic right shift applied to the accumulator before saturation.

Ports:
- clk  in  1: clock; all logic on rising edge.
- rst  in  1: synchronous, active-high reset.
- enable  in  1: start/hold; low aborts and clears.
- STOP  out  1: layer complete.
- memstartp  in  SIZE_address_pix: activation base address.
- memstartw  in  SIZE_address_wei: weight base address.
- memstartzap  in  SIZE_address_pix: output base address.
- qp  in  SIZE_1: activation read data, valid 1 cycle after address.
- qw  in  SIZE_1: weight read data, valid 1 cycle after address.
- re_p  out  1: activation read enable.
- re_w  out  1: weight read enable.
- read_addressp  out  SIZE_address_pix: activation read address.
- read_addressw  out  SIZE_address_wei: weight read address.
- we  out  1: output write enable.
- write_addressp  out  SIZE_address_pix: output write address.
- dp  out  SIZE_1: output write data.

Behaviour:
- Reset (rst=1) and enable=0 behave identically:
  - next edge forces STOP=0, re_p=0, re_w=0, we=0;
  - all address outputs=0, dp=0, accumulator=0, counters o=0 and i=0, state=IDLE.
  - rst has priority over enable.
- States: IDLE -> FETCH -> LAST -> WRITE -> (FETCH | DONE).
- IDLE: on enable=1, go to FETCH with i=0, o=0.
- FETCH, cycle with index i:
  - re_p=re_w=1; read_addressp=memstartp+i; read_addressw=memstartw+o*IN_NUM+i.
  - If i>0, acc += qp*qw, which is the data for index i-1.
  - When i=IN_NUM-1, go to LAST; otherwise i++.
- LAST: re_p=re_w=0; acc += qp*qw for index IN_NUM-1.
- WRITE:
  - we=1 for exactly one cycle; write_addressp=memstartzap+o.
  - dp = sat(acc>>>SHIFT), using an arithmetic shift.
  - acc clears; i=0.
  - If o=OUT_NUM-1, go to DONE; otherwise o++ and go to FETCH.
- DONE: STOP=1; all enables 0; remain while enable=1.
- STOP is never high in any other state.
- Product is a signed 2*SIZE_1-bit value.
- acc is signed, 2*SIZE_1+clog2(IN_NUM) bits, and never overflows.
- sat clamps to [-2^(SIZE_1-1), 2^(SIZE_1-1)-1]; the shift truncates toward -inf.
- Latency from first enable=1 edge to STOP=1 is exactly OUT_NUM*(IN_NUM+2)+1 cycles (IDLE exit + per-neuron IN_NUM fetch + LAST + WRITE).
- Default latency = 199 cycles.
- Abort: enable falling mid-layer discards partial acc and leaves no pending write. Re-enable restarts from neuron 0.
- Address arithmetic wraps modulo 2^width.
- Output addresses are never read by this block; overlap with the input region is a caller error.
- Operands are treated as signed only; no ReLU is applied, and the downstream stage compares signed scores.

Test Plan:
- All qp=1, qw=1, IN_NUM=16, SHIFT=0:
  - 11 writes, dp=16, addresses memstartzap+0..10.
  - STOP rises exactly 199 cycles after enable.
- Weight row o all equal o-5, activations all 2, SHIFT=0:
  - dp = 32*(o-5), i.e. -160..160.
  - Writes are signed-correct; a downstream argmax yields 10.
- Saturation: qp=qw=2047 (SIZE_1=12), SHIFT=0 -> dp=2047. qp=2047, qw=-2048 -> dp=-2048.
- Shift rounding: single product -3 (other terms 0), SHIFT=1 -> dp=-2.
- Abort: drop enable during neuron 4's FETCH, then re-enable:
  - no write occurs for neuron 4 before the drop;
  - the restart writes neuron 0 first, and full latency is 199 again.
- rst asserted with enable=1 in DONE:
  - next edge STOP=0, we=0.
  - After rst falls with enable still 1, the layer reruns fully.
